// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one 32-bit ALU between two requesters
module alu_share_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req1_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req0_shamt,
    input  logic [4:0]  req1_shamt,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_overflow,
    output logic        rsp_err,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [3:0]  alu_op,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        last;
    logic        owner;
    logic        grant;
    logic        accept;
    logic        legal;
    logic        is_addsub;
    logic [3:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [4:0]  sel_shamt;

    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
        req_ready = 2'b00;
        if (!rst && state == IDLE && req_valid != 2'b00)
            req_ready[grant] = 1'b1;
        accept    = (req_valid & req_ready) != 2'b00;
        sel_op    = grant ? req1_op    : req0_op;
        sel_a     = grant ? req1_a     : req0_a;
        sel_b     = grant ? req1_b     : req0_b;
        sel_shamt = grant ? req1_shamt : req0_shamt;
        legal     = (sel_op >= 4'd1) && (sel_op <= 4'd13);
        is_addsub = (alu_op == 4'b0001) || (alu_op == 4'b1010);
        rsp_valid = 2'b00;
        if (!rst && state == RESP)
            rsp_valid[owner] = 1'b1;
    end

    // The ALU-facing registers only load on a legal op, so an illegal opcode
    // never appears on alu_op and the ALU inputs stay quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last         <= 1'b1;
            owner        <= 1'b0;
            alu_op       <= 4'd0;
            alu_data1    <= 32'd0;
            alu_data2    <= 32'd0;
            alu_shamt    <= 5'd0;
            rsp_result   <= 32'd0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= grant;
                        if (legal) begin
                            alu_op    <= sel_op;
                            alu_data1 <= sel_a;
                            alu_data2 <= sel_b;
                            alu_shamt <= sel_shamt;
                            state     <= EXEC;
                        end else begin
                            rsp_result   <= 32'd0;
                            rsp_zero     <= 1'b0;
                            rsp_overflow <= 1'b0;
                            rsp_err      <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                EXEC: begin
                    rsp_result   <= alu_result;
                    rsp_zero     <= alu_zero;
                    rsp_overflow <= alu_overflow & is_addsub;
                    rsp_err      <= 1'b0;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        last  <= owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  f_op    [2];
    logic [31:0] f_a     [2];
    logic [31:0] f_b     [2];
    logic [4:0]  f_shamt [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_overflow;
    logic        rsp_err;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    logic        ovf_force;

    int vectors     = 0;
    int miscompares = 0;
    int last_m;
    logic [3:0]  alu_m_op;
    time acc_t;
    time prev_acc_t;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(f_op[0]), .req1_op(f_op[1]),
        .req0_a(f_a[0]), .req1_a(f_a[1]),
        .req0_b(f_b[0]), .req1_b(f_b[1]),
        .req0_shamt(f_shamt[0]), .req1_shamt(f_shamt[1]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
        .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
    );

    // Bench ALU: {overflow, result}. Non-add ops raise overflow on odd results so masking is exercised.
    function automatic logic [32:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        logic        v;
        r = 32'd0;
        v = 1'b0;
        case (op)
            4'b0001: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0010: r = a << sh;
            4'b0011: r = a & b;
            4'b0100: r = a | b;
            4'b0101: r = a ^ b;
            4'b0110: r = a >> sh;
            4'b0111: r = $unsigned($signed(a) >>> sh);
            4'b1000: r = {31'd0, $signed(a) < $signed(b)};
            4'b1001: r = {31'd0, a < b};
            4'b1010: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b1011: r = ~(a | b);
            4'b1100: r = a << b[4:0];
            4'b1101: r = b << 16;
            default: r = 32'd0;
        endcase
        if (op != 4'b0001 && op != 4'b1010)
            v = r[0];
        return {v, r};
    endfunction

    always_comb begin
        {alu_overflow, alu_result} = alu_f(alu_op, alu_data1, alu_data2, alu_shamt);
        alu_overflow = alu_overflow | ovf_force;
        alu_zero     = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input int i, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] sh);
        f_op[i] = op; f_a[i] = a; f_b[i] = b; f_shamt[i] = sh;
    endtask

    task automatic rand_fields(input int i);
        set_fields(i, 4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0) ? f_a[i] : $urandom,
                   5'($urandom_range(0, 31)));
    endtask

    // Called at a negedge while the DUT should be idle; runs one full transaction.
    task automatic do_txn(input logic [1:0] v, input int hold, input logic other_rdy);
        int          g;
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic [4:0]  sh;
        logic        ill, ovf, exp_ovf;
        g = (v == 2'b11) ? (1 - last_m) : (v[1] ? 1 : 0);
        req_valid = v;
        rsp_ready = 2'b00;
        #1;
        chk("grant", {30'd0, req_ready}, 32'(2'b01 << g));
        op = f_op[g]; a = f_a[g]; b = f_b[g]; sh = f_shamt[g];
        ill = (op == 4'd0) || (op > 4'd13);
        {ovf, res} = alu_f(op, a, b, sh);
        exp_ovf = (op == 4'b0001 || op == 4'b1010) ? (ovf | ovf_force) : 1'b0;
        @(posedge clk);
        prev_acc_t = acc_t;
        acc_t = $time;
        @(negedge clk);
        rand_fields(g);
        if (!ill) begin
            chk("exec_req_ready", {30'd0, req_ready}, 32'd0);
            chk("exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
            chk("alu_op", {28'd0, alu_op}, {28'd0, op});
            chk("alu_data1", alu_data1, a);
            chk("alu_data2", alu_data2, b);
            chk("alu_shamt", {27'd0, alu_shamt}, {27'd0, sh});
            alu_m_op = op;
            @(negedge clk);
        end else begin
            chk("alu_op_held", {28'd0, alu_op}, {28'd0, alu_m_op});
        end
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", {30'd0, rsp_valid}, 32'(2'b01 << g));
            chk("rsp_result", rsp_result, ill ? 32'd0 : res);
            chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, !ill && res == 32'd0});
            chk("rsp_overflow", {31'd0, rsp_overflow}, {31'd0, !ill && exp_ovf});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, ill});
            chk("resp_req_ready", {30'd0, req_ready}, 32'd0);
            if (i < hold) begin
                rsp_ready[1 - g] = other_rdy;
                @(negedge clk);
            end
        end
        rsp_ready[g] = 1'b1;
        @(posedge clk);
        last_m = g;
        @(negedge clk);
        rsp_ready = 2'b00;
        chk("post_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        last_m    = 1;
        alu_m_op  = 4'd0;
        acc_t     = 0;
        ovf_force = 1'b0;
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) set_fields(i, 4'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_alu_data1", alu_data1, 32'd0);
        rst = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("idle_no_req", {30'd0, req_ready}, 32'd0);

        // Single ADD with signed overflow
        set_fields(0, 4'b0001, 32'h7FFF_FFFF, 32'd1, 5'd0);
        do_txn(2'b01, 0, 1'b0);

        // Tie with round-robin, a new grant every 3 cycles
        for (int k = 0; k < 4; k++) begin
            set_fields(0, 4'b0001, 32'd3, 32'd4, 5'd0);
            set_fields(1, 4'b1010, 32'd9, 32'd9, 5'd0);
            do_txn(2'b11, 0, 1'b0);
            if (k > 0) chk("tie_period", 32'(acc_t - prev_acc_t), 32'd30);
        end

        // Overflow masking on a non-arithmetic op
        ovf_force = 1'b1;
        set_fields(1, 4'b0011, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0);
        do_txn(2'b10, 0, 1'b0);
        ovf_force = 1'b0;

        // Illegal opcode
        set_fields(0, 4'b1111, 32'h1234_5678, 32'h9, 5'd3);
        do_txn(2'b01, 0, 1'b0);

        // Backpressure, non-owner ready ignored
        set_fields(0, 4'b0101, 32'hA5A5_0000, 32'h0000_5A5A, 5'd0);
        do_txn(2'b01, 5, 1'b1);

        // Reset during EXEC discards the transaction
        set_fields(0, 4'b0001, 32'd1, 32'd2, 5'd0);
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b11;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("midrst_alu_op", {28'd0, alu_op}, 32'd0);
        rst = 1'b0;
        last_m = 1;
        alu_m_op = 4'd0;
        set_fields(0, 4'b0100, 32'hF000_0000, 32'h0000_000F, 5'd0);
        set_fields(1, 4'b0001, 32'd5, 32'd6, 5'd0);
        do_txn(2'b11, 0, 1'b0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 60; k++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            rand_fields(0);
            rand_fields(1);
            ovf_force = ($urandom_range(0, 7) == 0);
            do_txn(v, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
